// File: rtl/fpu_pkg.sv
// fpu_pkg: shared definitions for the FPU sequencer.
// - FPU op encodings (5-bit), sequencer state enum, counter width,
//   and the latency-lookup result struct.
package fpu_pkg;

    localparam int CNT_W = 5;

    typedef enum logic [4:0] {
        FADD     = 5'b00000,
        FSUB     = 5'b00001,
        FMUL     = 5'b00010,
        FDIV     = 5'b00011,
        FSQRT    = 5'b00100,
        FCVT_L_D = 5'b00101,
        FCVT_D_L = 5'b00110,
        FMV_X_D  = 5'b00111,
        FMV_D_X  = 5'b01000
    } fpu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic             legal;
        logic [CNT_W-1:0] lat;
    } lat_info_t;

endpackage

// File: rtl/fpu_lat_lut.sv
// fpu_lat_lut: combinational op -> {legal, latency} lookup.
// Ports:
//   op_i   in  5        FPU op code
//   info_o out struct   legal flag and budgeted latency (0 when illegal)
module fpu_lat_lut
    import fpu_pkg::*;
#(
    parameter int unsigned LAT_ADD  = 2,
    parameter int unsigned LAT_MUL  = 3,
    parameter int unsigned LAT_DIV  = 12,
    parameter int unsigned LAT_SQRT = 16,
    parameter int unsigned LAT_CVT  = 2
) (
    input  logic [4:0] op_i,
    output lat_info_t  info_o
);

    // Decode the op into its latency budget; codes above FMV_D_X are illegal.
    always_comb begin
        info_o.legal = 1'b1;
        info_o.lat   = CNT_W'(1);
        case (op_i)
            FADD, FSUB:         info_o.lat = CNT_W'(LAT_ADD);
            FMUL:               info_o.lat = CNT_W'(LAT_MUL);
            FDIV:               info_o.lat = CNT_W'(LAT_DIV);
            FSQRT:              info_o.lat = CNT_W'(LAT_SQRT);
            FCVT_L_D, FCVT_D_L: info_o.lat = CNT_W'(LAT_CVT);
            FMV_X_D, FMV_D_X:   info_o.lat = CNT_W'(1);
            default: begin
                info_o.legal = 1'b0;
                info_o.lat   = CNT_W'(0);
            end
        endcase
    end

endmodule

// File: rtl/fpu_seq_ctrl.sv
// fpu_seq_ctrl: multi-cycle sequencer in front of a combinational FPU.
// Accepts one op (valid/ready), holds op/operands stable for the op's
// latency budget, captures the FPU result and presents it on a
// valid/ready response port.
// Ports:
//   clk_i, rst_i (sync, active-high), flush_i (sync abort)
//   req_*   : issue request (valid/ready, op, operands, rd)
//   fpu_*_o : registered op/operands to FPU; fpu_out_i/fpu_rd_i back
//   resp_*  : response (valid/ready, data, rd, rd_fp, illegal)
//   busy_o  : state != IDLE; retired_cnt_o: completed handshakes (mod 2^32)
module fpu_seq_ctrl
    import fpu_pkg::*;
#(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned LAT_ADD  = 2,
    parameter int unsigned LAT_MUL  = 3,
    parameter int unsigned LAT_DIV  = 12,
    parameter int unsigned LAT_SQRT = 16,
    parameter int unsigned LAT_CVT  = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [4:0]      req_op_i,
    input  logic [XLEN-1:0] req_rs1_val_i,
    input  logic [XLEN-1:0] req_rs2_val_i,
    input  logic [4:0]      req_rd_i,
    output logic [4:0]      fpu_op_o,
    output logic [XLEN-1:0] fpu_in1_o,
    output logic [XLEN-1:0] fpu_in2_o,
    input  logic [XLEN-1:0] fpu_out_i,
    input  logic            fpu_rd_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] resp_data_o,
    output logic [4:0]      resp_rd_o,
    output logic            resp_rd_fp_o,
    output logic            resp_illegal_o,
    output logic            busy_o,
    output logic [31:0]     retired_cnt_o
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [4:0]        op_q;
    logic [XLEN-1:0]   in1_q, in2_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   resp_data_q;
    logic              rd_fp_q;
    logic              illegal_q;
    logic [31:0]       retired_q;
    lat_info_t         lat_info;
    logic              accept;
    logic              handshake;

    fpu_lat_lut #(
        .LAT_ADD  (LAT_ADD),
        .LAT_MUL  (LAT_MUL),
        .LAT_DIV  (LAT_DIV),
        .LAT_SQRT (LAT_SQRT),
        .LAT_CVT  (LAT_CVT)
    ) u_lat_lut (
        .op_i   (req_op_i),
        .info_o (lat_info)
    );

    assign accept    = req_valid_i && req_ready_o;
    // flush overrides a response handshake, so it never retires.
    assign handshake = (state_q == ST_DONE) && resp_ready_i && !flush_i;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush dominates every transition.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_d = lat_info.legal ? ST_EXEC : ST_DONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    if (cnt_q == CNT_W'(0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
                ST_DONE: begin
                    if (handshake) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs decoded from the registered state.
    always_comb begin
        req_ready_o  = 1'b0;
        busy_o       = 1'b1;
        resp_valid_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready_o = !flush_i;
                busy_o      = 1'b0;
            end
            ST_EXEC: begin
                busy_o = 1'b1;
            end
            ST_DONE: begin
                resp_valid_o = 1'b1;
            end
            default: begin
                busy_o = 1'b1;
            end
        endcase
    end

    // Operand latch, latency counter, result capture and retire counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q       <= CNT_W'(0);
            op_q        <= 5'd0;
            in1_q       <= '0;
            in2_q       <= '0;
            rd_q        <= 5'd0;
            resp_data_q <= '0;
            rd_fp_q     <= 1'b0;
            illegal_q   <= 1'b0;
            retired_q   <= 32'd0;
        end else begin
            if (accept) begin
                op_q      <= req_op_i;
                in1_q     <= req_rs1_val_i;
                in2_q     <= req_rs2_val_i;
                rd_q      <= req_rd_i;
                illegal_q <= !lat_info.legal;
                if (lat_info.legal) begin
                    cnt_q <= lat_info.lat - CNT_W'(1);
                end else begin
                    // Illegal ops go straight to DONE with a zeroed result.
                    cnt_q       <= CNT_W'(0);
                    resp_data_q <= '0;
                    rd_fp_q     <= 1'b0;
                end
            end else if (state_q == ST_EXEC && !flush_i) begin
                if (cnt_q == CNT_W'(0)) begin
                    resp_data_q <= fpu_out_i;
                    rd_fp_q     <= fpu_rd_i;
                end else begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
            end else begin
                cnt_q <= cnt_q;
            end
            if (handshake) begin
                retired_q <= retired_q + 32'd1;
            end else begin
                retired_q <= retired_q;
            end
        end
    end

    assign fpu_op_o       = op_q;
    assign fpu_in1_o      = in1_q;
    assign fpu_in2_o      = in2_q;
    assign resp_data_o    = resp_data_q;
    assign resp_rd_o      = rd_q;
    assign resp_rd_fp_o   = rd_fp_q;
    assign resp_illegal_o = illegal_q;
    assign retired_cnt_o  = retired_q;

endmodule
